// File: rtl/fire_lfsr_divider.sv
// Bit-serial polynomial division register for the Fire-code codec.
// A parallel word is latched on start and consumed MSB-first, one bit per
// accepted shift. Once the word is exhausted, zeros are shifted in so the
// decoder can keep clocking the register for error trapping.
// PREMULT=1 gives the encoder form (x^r * m(x) mod g).
// PREMULT=0 gives the syndrome form (m(x) mod g).
module fire_lfsr_divider #(
  parameter int                 WIDTH     = 24,
  parameter logic [WIDTH-1:0]   POLY      = '0,
  parameter int                 DATA_W    = 64,
  parameter int                 PREMULT   = 0,
  parameter logic [WIDTH-1:0]   TRAP_MASK = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [WIDTH-1:0]  rem,
  output logic [10:0]       count,
  output logic              data_done,
  output logic              trap_zero
);

  // The bit index must be able to hold DATA_W itself, which marks the word as exhausted.
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [10:0]      CNT_MAX  = 11'd2047;

  logic [DATA_W-1:0] buffer;
  logic [IDX_W-1:0]  idx;
  logic              data_avail;
  logic              bit_in;
  logic              fb;
  logic [WIDTH-1:0]  rem_shifted;
  logic [WIDTH-1:0]  rem_next;

  // Select the input bit and compute one division step from the current remainder.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    data_avail  = (idx != IDX_END);
    bit_in      = 1'b0;
    fb          = 1'b0;
    rem_shifted = '0;
    if (data_avail) begin
      bit_in = buffer[DATA_W-1];
    end
    if (PREMULT != 0) begin
      // Encoder form: the message bit enters at the top, which folds in the x^r factor.
      fb          = rem[WIDTH-1] ^ bit_in;
      rem_shifted = {rem[WIDTH-2:0], 1'b0};
    end else begin
      // Syndrome form: the message bit enters at the bottom.
      fb          = rem[WIDTH-1];
      rem_shifted = {rem[WIDTH-2:0], bit_in};
    end
    rem_next = rem_shifted ^ (fb ? POLY : '0);
  end

  // State register: start has priority over shift, and shift=0 holds everything.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: the input buffer is a plain register rather than a memory, so it is cleared on reset with the rest of the state.
      buffer    <= '0;
      idx       <= '0;
      rem       <= '0;
      count     <= '0;
      data_done <= 1'b0;
    end else if (start) begin
      buffer    <= din;
      idx       <= '0;
      rem       <= '0;
      count     <= '0;
      data_done <= 1'b0;
    end else if (shift) begin
      buffer <= {buffer[DATA_W-2:0], 1'b0};
      rem    <= rem_next;
      if (data_avail) begin
        idx <= idx + IDX_W'(1);
      end
      if (idx == IDX_LAST) begin
        data_done <= 1'b1;
      end
      if (count != CNT_MAX) begin
        count <= count + 11'd1;
      end
    end
  end

  // Trap detection looks only at the masked remainder bits and is valid as soon as rem changes.
  assign trap_zero = ((rem & TRAP_MASK) == '0);

endmodule

// File: tb/tb_fire_lfsr_divider.sv
// Self-checking bench for fire_lfsr_divider.
// Small 4-bit instances cover directed cases and randomized shift patterns.
// A 24-bit encoder/decoder pair covers the full Fire-code round trip.
// Expected remainders come from GF(2) polynomial long division.
module tb_fire_lfsr_divider;

  localparam logic [3:0]  SP      = 4'b0011;
  localparam logic [23:0] FP      = 24'h088211; // (x^15+1)(x^9+x^4+1), low 24 coefficients
  localparam logic [3:0]  TMASK   = 4'b0111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Small instances share start/shift; the trap instance has its own data word.
  logic        start = 1'b0;
  logic        shift = 1'b0;
  logic [7:0]  din   = '0;
  logic [7:0]  din_t = '0;
  logic [3:0]  rem_s, rem_e, rem_t;
  logic [10:0] cnt_s, cnt_e, cnt_t;
  logic        dd_s, dd_e, dd_t;
  logic        tz_s, tz_e, tz_t;

  // Fire-code pair.
  logic        f_start = 1'b0;
  logic        f_shift = 1'b0;
  logic [39:0] f_din_e = '0;
  logic [63:0] f_din_d = '0;
  logic [23:0] f_rem_e, f_rem_d;
  logic [10:0] f_cnt_e, f_cnt_d;
  logic        f_dd_e, f_dd_d, f_tz_e, f_tz_d;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fire_lfsr_divider #(.WIDTH(4), .POLY(SP), .DATA_W(8), .PREMULT(0)) u_syn (
    .clk(clk), .rst(rst), .start(start), .shift(shift), .din(din),
    .rem(rem_s), .count(cnt_s), .data_done(dd_s), .trap_zero(tz_s));

  fire_lfsr_divider #(.WIDTH(4), .POLY(SP), .DATA_W(8), .PREMULT(1)) u_enc (
    .clk(clk), .rst(rst), .start(start), .shift(shift), .din(din),
    .rem(rem_e), .count(cnt_e), .data_done(dd_e), .trap_zero(tz_e));

  fire_lfsr_divider #(.WIDTH(4), .POLY(SP), .DATA_W(8), .PREMULT(0), .TRAP_MASK(TMASK)) u_trap (
    .clk(clk), .rst(rst), .start(start), .shift(shift), .din(din_t),
    .rem(rem_t), .count(cnt_t), .data_done(dd_t), .trap_zero(tz_t));

  fire_lfsr_divider #(.WIDTH(24), .POLY(FP), .DATA_W(40), .PREMULT(1)) u_fenc (
    .clk(clk), .rst(rst), .start(f_start), .shift(f_shift), .din(f_din_e),
    .rem(f_rem_e), .count(f_cnt_e), .data_done(f_dd_e), .trap_zero(f_tz_e));

  fire_lfsr_divider #(.WIDTH(24), .POLY(FP), .DATA_W(64), .PREMULT(0)) u_fdec (
    .clk(clk), .rst(rst), .start(f_start), .shift(f_shift), .din(f_din_d),
    .rem(f_rem_d), .count(f_cnt_d), .data_done(f_dd_d), .trap_zero(f_tz_d));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Remainder of the first k consumed bits (zeros after the word runs out),
  // optionally premultiplied by x^r, modulo x^r + poly_low.
  function automatic logic [127:0] ref_rem(input logic [63:0] word, input int dw, input int k,
                                           input int r, input logic [127:0] poly_low,
                                           input bit premult);
    logic [127:0] a;
    logic [127:0] g;
    if (k <= dw) a = 128'(word) >> (dw - k);
    else         a = 128'(word) << (k - dw);
    if (premult) a = a << r;
    g = poly_low | (128'd1 << r);
    for (int i = 127; i >= r; i--) begin
      if (a[i]) a = a ^ (g << (i - r));
    end
    return a;
  endfunction

  initial begin
    logic [7:0]   w;
    logic [39:0]  msg;
    logic [127:0] par;
    int           k;

    // Reset state.
    #1;
    check("reset_rem", rem_s, 4'd0);
    check("reset_count", cnt_s, 11'd0);
    check("reset_done", dd_s, 1'b0);
    #3 rst = 1'b0;

    // Syndrome and encoder division of 8'h80.
    din = 8'h80; start = 1'b1; tick(); start = 1'b0;
    shift = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("syn_done_%0d", i), dd_s, (i == 8));
    end
    check("syn_rem8", rem_s, 4'b1011);
    check("syn_cnt8", cnt_s, 11'd8);
    check("enc_rem8", rem_e, 4'b1110);
    check("enc_cnt8", cnt_e, 11'd8);
    check("enc_trap8", tz_e, 1'b0);
    tick();
    check("syn_rem9", rem_s, 4'b0101);
    check("syn_cnt9", cnt_s, 11'd9);
    shift = 1'b0;

    // Pause/resume: 3 shifts, 5 idle cycles, 5 shifts.
    start = 1'b1; tick(); start = 1'b0;
    shift = 1'b1;
    repeat (3) tick();
    shift = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pause_rem", rem_s, 4'b0100);
      check("pause_cnt", cnt_s, 11'd3);
    end
    shift = 1'b1;
    repeat (5) tick();
    shift = 1'b0;
    check("resume_rem", rem_s, 4'b1011);
    check("resume_cnt", cnt_s, 11'd8);

    // start and shift together: start wins and the first bit is not consumed.
    shift = 1'b1; start = 1'b1; tick(); start = 1'b0;
    check("prio_cnt", cnt_s, 11'd0);
    check("prio_rem", rem_s, 4'd0);
    repeat (8) tick();
    check("prio_rem8", rem_s, 4'b1011);
    check("prio_cnt8", cnt_s, 11'd8);

    // Count saturation.
    repeat (2092) tick();
    check("sat_cnt", cnt_s, 11'd2047);
    check("sat_cnt_enc", cnt_e, 11'd2047);
    check("sat_done", dd_s, 1'b1);

    // Asynchronous reset mid-shift.
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    check("pre_rst_rem", rem_s, 4'b0011);
    #2 rst = 1'b1;
    #1;
    check("async_rem", rem_s, 4'd0);
    check("async_cnt", cnt_s, 11'd0);
    check("async_done", dd_s, 1'b0);
    check("async_rem_enc", rem_e, 4'd0);
    #1 rst = 1'b0; shift = 1'b0;
    tick();

    // Trap flag with a partial mask.
    din_t = 8'h00; start = 1'b1; tick(); start = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("trap0_rem", rem_t, 4'd0);
      check("trap0_flag", tz_t, 1'b1);
    end
    shift = 1'b0;
    din_t = 8'h01; start = 1'b1; tick(); start = 1'b0;
    shift = 1'b1;
    repeat (8) tick();
    shift = 1'b0;
    check("trap1_rem", rem_t, 4'b0001);
    check("trap1_flag", tz_t, 1'b0);

    // Randomized shift patterns against the polynomial model.
    for (int t = 0; t < 6; t++) begin
      w = 8'($urandom);
      din = w; start = 1'b1; tick(); start = 1'b0;
      k = 0;
      for (int c = 0; c < 20; c++) begin
        shift = ($urandom_range(0, 9) < 7);
        tick();
        if (shift) k++;
        check("rnd_syn_rem", rem_s, ref_rem({56'd0, w}, 8, k, 4, 128'(SP), 1'b0));
        check("rnd_enc_rem", rem_e, ref_rem({56'd0, w}, 8, k, 4, 128'(SP), 1'b1));
        check("rnd_cnt", cnt_s, 11'(k));
        check("rnd_done", dd_s, (k >= 8));
        check("rnd_trap", tz_s, (ref_rem({56'd0, w}, 8, k, 4, 128'(SP), 1'b0) == 0));
      end
      shift = 1'b0;
    end

    // Fire-code round trip: encode a random 40-bit message, decode the codeword.
    msg = {8'($urandom), 32'($urandom)};
    par = ref_rem({24'd0, msg}, 40, 40, 24, 128'(FP), 1'b1);
    f_din_e = msg;
    f_din_d = {msg, par[23:0]};
    f_start = 1'b1; tick(); f_start = 1'b0;
    f_shift = 1'b1;
    repeat (40) tick();
    check("fire_enc_rem", f_rem_e, par[23:0]);
    check("fire_enc_done", f_dd_e, 1'b1);
    check("fire_dec_done40", f_dd_d, 1'b0);
    repeat (24) tick();
    f_shift = 1'b0;
    check("fire_dec_rem", f_rem_d, 24'd0);
    check("fire_dec_trap", f_tz_d, 1'b1);
    check("fire_dec_cnt", f_cnt_d, 11'd64);
    check("fire_dec_done", f_dd_d, 1'b1);

    // Corrupted codeword must leave a nonzero syndrome.
    f_din_d = {msg, par[23:0]} ^ 64'h0000_0100_0000_0000;
    f_start = 1'b1; tick(); f_start = 1'b0;
    f_shift = 1'b1;
    repeat (64) tick();
    f_shift = 1'b0;
    check("fire_err_rem", f_rem_d, ref_rem(f_din_d, 64, 64, 24, 128'(FP), 1'b0));
    check("fire_err_trap", f_tz_d, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
